decoder_3to8_pulse: RTL and testbench
=====================================

Name: decoder_3to8_pulse

Overview:
- Sequential 3-to-8 one-hot decoder with a valid/ready input handshake and a timed output pulse.
- It is the inverse of the team's 8-to-3 priority encoder and drives one-hot select/strobe lines from an encoded index.
- Each accepted code is held as a one-hot output for HOLD_CYCLES cycles, followed by an optional GAP_CYCLES dead time.
- Round-trip property: feeding out_onehot into the 8-to-3 encoder returns the accepted code, and the encoder's valid flag equals out_valid.

Parameters:
- HOLD_CYCLES, 4, cycles out_onehot stays asserted per accepted code; legal range 1..255.
- GAP_CYCLES, 1, all-zero cycles after the hold before the next accept; legal range 0..255.
- CNT_W, 8, width of the internal hold/gap counter; must hold max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_code  in  3  encoded index to decode.
- in_valid  in  1  in_code is valid this cycle.
- in_ready  out  1  block can accept a code this cycle.
- out_onehot  out  8  one-hot decode (bit in_code set) or all zero.
- out_valid  out  1  equals |out_onehot.
- busy  out  1  state is not IDLE.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset: asserting rst_n low immediately forces state=IDLE, counter=0, out_onehot=8'h00, out_valid=0. in_ready=1 after reset releases; busy=0.
- in_ready is combinational from registered state only: in_ready = (state==IDLE). There is no combinational path from in_valid.
- Accept: in_valid && in_ready at rising edge N.
  - After edge N: out_onehot = 8'b1 << in_code, out_valid=1, state=HOLD, counter=HOLD_CYCLES-1.
  - Latency is one cycle (the edge that accepts).
- HOLD:
  - out_onehot is constant; in_ready=0; in_valid is ignored and no code is queued.
  - At counter==0 the next edge clears out_onehot to 0.
  - It then moves to GAP with counter=GAP_CYCLES-1 if GAP_CYCLES>0, else to IDLE.
  - Otherwise the counter decrements.
- GAP: out_onehot=0, in_ready=0. At counter==0 move to IDLE, else decrement.
- Throughput: one code per HOLD_CYCLES+GAP_CYCLES+1 cycles minimum, because the IDLE accept cycle is counted. Back-to-back in_valid held high is accepted exactly once per period.
- Invariant: out_onehot is always zero or exactly one bit set. out_valid == |out_onehot at all times.
- Input code is only ever 0..7, so there is no illegal value. in_code is sampled only on the accept edge.
- Reset mid-HOLD/GAP: outputs clear asynchronously and the pending pulse is abandoned (not resumed).
- HOLD_CYCLES==1: pulse is exactly one cycle wide.

Optional Feature:
- Macro: DEC_PARITY_CHK_EN.
- Defined:
  - Adds input in_parity (1) and output parity_err (1, reset 0).
  - Odd parity is required over {in_parity, in_code}.
  - On accept with bad parity: the handshake still completes, out_onehot stays 0, and state stays IDLE.
  - parity_err pulses high for exactly one cycle after that edge.
  - Good parity behaves as the base design.
- Undefined: no extra ports and no parity logic.

Decomposition:
- Package decoder_pkg holds:
  - constants CODE_W=3 and ONEHOT_W=8;
  - typedef enum dec_state_t {IDLE, HOLD, GAP} (2-bit);
  - function onehot_of(code).
- Sub-module: dec_hold_timer.
  - Inputs: load, load_val[CNT_W].
  - Behaviour: decrements while nonzero; outputs zero flag.
  - Shared for hold and gap.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> out_onehot=8'h00, out_valid=0, busy=0; after release in_ready=1.
- Single accept, in_code=3'd5, HOLD=4, GAP=1:
  - out_onehot=8'h20 for exactly 4 cycles, then 0 for 1 cycle;
  - in_ready returns high on cycle 6 after accept.
- Sweep codes 0..7 with in_valid held high:
  - outputs 8'h01,8'h02,...,8'h80 in order, each accepted once per 6-cycle period;
  - encoder model of out_onehot == code.
- HOLD=1, GAP=0: in_code=3'd0 accepted -> 8'h01 for one cycle, then in_ready=1 the next cycle; next accept gives a 2-cycle period.
- Reset mid-HOLD (code 3'd7, assert rst_n low on hold cycle 2) -> out_onehot 8'h80 drops to 0 asynchronously without a clock edge; state=IDLE after release.
- With DEC_PARITY_CHK_EN: code 3'd6 with in_parity=0 (even total) -> parity_err one-cycle pulse, out_onehot stays 0; code 3'd6 with in_parity=1 -> 8'h40 held.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the 3-to-8 pulse decoder.
// Holds code/one-hot widths, FSM state type and the one-hot helper.
package decoder_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } dec_state_t;

  function automatic logic [ONEHOT_W-1:0] onehot_of(
    input logic [CODE_W-1:0] code
  );
    logic [ONEHOT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec_hold_timer.sv
// Down-counter shared by the hold and gap phases of the decoder.
// Ports: clk, rst_n (async low), load, load_val -> zero (count is 0).
module dec_hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_3to8_pulse.sv
// Sequential 3-to-8 one-hot decoder: each accepted code is held as a
// one-hot pulse for HOLD_CYCLES, then GAP_CYCLES of dead time.
// Ports: clk, rst_n (async low), in_code[3], in_valid -> in_ready,
//   out_onehot[8], out_valid, busy.
// Optional macro DEC_PARITY_CHK_EN adds in_parity / parity_err
//   (odd parity over {in_parity, in_code}; bad codes are dropped).
module decoder_3to8_pulse
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CODE_W-1:0]   in_code,
  input  logic                in_valid,
`ifdef DEC_PARITY_CHK_EN
  input  logic                in_parity,
  output logic                parity_err,
`endif
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] out_onehot,
  output logic                out_valid,
  output logic                busy
);

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_CYCLES - 1);
  localparam logic             HAS_GAP = (GAP_CYCLES > 0);

  dec_state_t          state_q;
  dec_state_t          state_d;
  logic [ONEHOT_W-1:0] onehot_q;
  logic [ONEHOT_W-1:0] onehot_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  logic accept;
  logic code_ok;

`ifdef DEC_PARITY_CHK_EN
  logic perr_q;
  logic perr_d;

  assign code_ok = ^{in_parity, in_code};
`else
  assign code_ok = 1'b1;
`endif

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept && code_ok) begin
          state_d  = HOLD;
          onehot_d = onehot_of(in_code);
          tmr_load = 1'b1;
          tmr_val  = HOLD_M1;
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          onehot_d = '0;
          if (HAS_GAP) begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_M1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (tmr_zero) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
      end
    endcase
  end

`ifdef DEC_PARITY_CHK_EN
  // A rejected code still completes the handshake; flag it for one cycle.
  assign perr_d     = accept && !code_ok;
  assign parity_err = perr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      onehot_q <= '0;
`ifdef DEC_PARITY_CHK_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
`ifdef DEC_PARITY_CHK_EN
      perr_q   <= perr_d;
`endif
    end
  end

  dec_hold_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  assign out_onehot = onehot_q;
  assign out_valid  = |onehot_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// Bench for decoder_3to8_pulse: two instances (4/1 and 1/0 timing)
// driven together and compared each cycle against a pulse model.
module tb_decoder_3to8_pulse;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i   [2];
  logic [2:0] code_i  [2];
  logic       valid_i [2];
  logic [7:0] oh_o    [2];
  logic       ov_o    [2];
  logic       rdy_o   [2];
  logic       busy_o  [2];
`ifdef DEC_PARITY_CHK_EN
  logic       par_i   [2];
  logic       perr_o  [2];
`endif

  int errors = 0;
  int checks = 0;

  // Model: cycles of pulse and dead time still to run, per instance.
  int         hold_left [2];
  int         gap_left  [2];
  logic [2:0] mcode     [2];
  logic       mperr     [2];

  decoder_3to8_pulse #(
    .HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)
  ) u_a (
`ifdef DEC_PARITY_CHK_EN
    .in_parity (par_i[0]),
    .parity_err(perr_o[0]),
`endif
    .clk       (clk),
    .rst_n     (rst_i[0]),
    .in_code   (code_i[0]),
    .in_valid  (valid_i[0]),
    .in_ready  (rdy_o[0]),
    .out_onehot(oh_o[0]),
    .out_valid (ov_o[0]),
    .busy      (busy_o[0])
  );

  decoder_3to8_pulse #(
    .HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)
  ) u_b (
`ifdef DEC_PARITY_CHK_EN
    .in_parity (par_i[1]),
    .parity_err(perr_o[1]),
`endif
    .clk       (clk),
    .rst_n     (rst_i[1]),
    .in_code   (code_i[1]),
    .in_valid  (valid_i[1]),
    .in_ready  (rdy_o[1]),
    .out_onehot(oh_o[1]),
    .out_valid (ov_o[1]),
    .busy      (busy_o[1])
  );

  function automatic int hold_of(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic logic idle_of(int d);
    return (hold_left[d] == 0) && (gap_left[d] == 0);
  endfunction

  function automatic logic [7:0] exp_oh(int d);
    if (hold_left[d] > 0) return 8'(1 << mcode[d]);
    return 8'h00;
  endfunction

  // Reference 8-to-3 encoder for the round-trip check.
  function automatic logic [2:0] enc_code(logic [7:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) c = 3'(i);
    return c;
  endfunction

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset(int d);
    hold_left[d] = 0;
    gap_left[d]  = 0;
    mcode[d]     = 3'd0;
    mperr[d]     = 1'b0;
  endtask

  task automatic model_edge();
    logic good;
    for (int d = 0; d < 2; d++) begin
      if (!rst_i[d]) begin
        model_reset(d);
      end else begin
        mperr[d] = 1'b0;
`ifdef DEC_PARITY_CHK_EN
        good = ((code_i[d][0] + code_i[d][1] + code_i[d][2]
                 + par_i[d]) % 2) == 1;
`else
        good = 1'b1;
`endif
        if (idle_of(d) && valid_i[d]) begin
          if (good) begin
            hold_left[d] = hold_of(d);
            gap_left[d]  = gap_of(d);
            mcode[d]     = code_i[d];
          end else begin
            mperr[d] = 1'b1;
          end
        end else if (hold_left[d] > 0) begin
          hold_left[d]--;
        end else if (gap_left[d] > 0) begin
          gap_left[d]--;
        end
      end
    end
  endtask

  task automatic check_one(int d);
    logic [7:0] e;
    e = exp_oh(d);
    chk("onehot", d, 32'(oh_o[d]), 32'(e));
    chk("out_valid", d, 32'(ov_o[d]), 32'(e != 8'h00));
    chk("in_ready", d, 32'(rdy_o[d]), 32'(idle_of(d)));
    chk("busy", d, 32'(busy_o[d]), 32'(!idle_of(d)));
    chk("enc_valid", d, 32'(|oh_o[d]), 32'(ov_o[d]));
    if (e != 8'h00) chk("enc_code", d, 32'(enc_code(oh_o[d])), 32'(mcode[d]));
`ifdef DEC_PARITY_CHK_EN
    chk("parity_err", d, 32'(perr_o[d]), 32'(mperr[d]));
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_one(d);
  endtask

  task automatic set_in(int d, logic v, logic [2:0] c);
    valid_i[d] = v;
    code_i[d]  = c;
`ifdef DEC_PARITY_CHK_EN
    par_i[d]   = ~^c;
`endif
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_i[d] = 1'b0;
      set_in(d, 1'b0, 3'd0);
      model_reset(d);
    end
    #1;
    for (int d = 0; d < 2; d++) check_one(d);
    repeat (3) step();
    rst_i[0] = 1'b1;
    rst_i[1] = 1'b1;
    step();

    // Single accept: code 5 on the 4/1 instance, code 0 on the 1/0 one.
    set_in(0, 1'b1, 3'd5);
    set_in(1, 1'b1, 3'd0);
    step();
    set_in(0, 1'b0, 3'd0);
    set_in(1, 1'b0, 3'd0);
    chk("hold_start", 0, 32'(oh_o[0]), 32'h20);
    repeat (8) step();

    // Sweep with valid held high; the 1/0 instance gets a 2-cycle period.
    for (int c = 0; c < 8; c++) begin
      set_in(0, 1'b1, 3'(c));
      set_in(1, 1'b1, 3'(7 - c));
      repeat (6) step();
    end
    set_in(0, 1'b0, 3'd0);
    set_in(1, 1'b0, 3'd0);
    repeat (6) step();

    // Reset during hold cycle 2 of code 7: outputs drop with no edge.
    set_in(0, 1'b1, 3'd7);
    step();
    set_in(0, 1'b0, 3'd0);
    step();
    chk("pre_reset", 0, 32'(oh_o[0]), 32'h80);
    rst_i[0] = 1'b0;
    #1;
    model_reset(0);
    check_one(0);
    step();
    rst_i[0] = 1'b1;
    repeat (2) step();

`ifdef DEC_PARITY_CHK_EN
    // Bad parity on code 6 is dropped; good parity is held.
    valid_i[0] = 1'b1;
    code_i[0]  = 3'd6;
    par_i[0]   = 1'b0;
    step();
    valid_i[0] = 1'b0;
    step();
    valid_i[0] = 1'b1;
    par_i[0]   = 1'b1;
    step();
    valid_i[0] = 1'b0;
    repeat (6) step();
`endif

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 300; n++) begin
      for (int d = 0; d < 2; d++) begin
        rst_i[d]   = ($urandom_range(0, 59) != 0);
        valid_i[d] = ($urandom_range(0, 3) != 0);
        code_i[d]  = 3'($urandom_range(0, 7));
`ifdef DEC_PARITY_CHK_EN
        par_i[d]   = ($urandom_range(0, 3) != 0) ? ~^code_i[d]
                                                 : ^code_i[d];
`endif
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
